ar_qos_request_arbiter: RTL

//  Multi-channel AXI read-address ingress buffer.
//  - NUM_CH independent AR sources each get their own request FIFO.
//  - A QoS-aware round-robin arbiter with starvation aging merges them into one registered AR output toward tag remapping.
//  - Each output beat carries the source channel index so responses can be routed back.

---
 rtl/ar_qos_request_arbiter_if.sv | 47 ++++
 rtl/ar_qos_request_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ar_qos_request_arbiter_if.sv
// rtl/ar_qos_request_arbiter_if.sv - AR ingress channels and merged AR egress bundle
// slave is the arbiter's view; master is the traffic source/sink view.
interface ar_qos_request_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 8
);
    localparam int SRC_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*ID_WIDTH-1:0]   in_id;
    logic [NUM_CH*ADDR_WIDTH-1:0] in_addr;
    logic [NUM_CH*LEN_WIDTH-1:0]  in_len;
    logic [NUM_CH*3-1:0]          in_size;
    logic [NUM_CH*2-1:0]          in_burst;
    logic [NUM_CH*4-1:0]          in_qos;
    logic [NUM_CH*TAG_WIDTH-1:0]  in_tagid;

    logic                         out_valid;
    logic                         out_ready;
    logic [ID_WIDTH-1:0]          out_id;
    logic [ADDR_WIDTH-1:0]        out_addr;
    logic [LEN_WIDTH-1:0]         out_len;
    logic [2:0]                   out_size;
    logic [1:0]                   out_burst;
    logic [3:0]                   out_qos;
    logic [TAG_WIDTH-1:0]         out_tagid;
    logic [SRC_W-1:0]             out_src;
    logic [NUM_CH*CNT_W-1:0]      occupancy;

    modport slave (
        input  in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos, in_tagid, out_ready,
        output in_ready, out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
               out_tagid, out_src, occupancy
    );

    modport master (
        output in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos, in_tagid, out_ready,
        input  in_ready, out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
               out_tagid, out_src, occupancy
    );
endinterface

// File: rtl/ar_qos_request_arbiter.sv
// rtl/ar_qos_request_arbiter.sv - per-channel AR FIFOs merged by a QoS round-robin arbiter with aging
// The winning head is copied into a registered output stage tagged with its source channel.
module ar_qos_request_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 8,
    parameter int AGE_LIMIT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    ar_qos_request_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [3:0]            qos;
        logic [TAG_WIDTH-1:0]  tagid;
    } entry_t;

    entry_t             mem      [NUM_CH][DEPTH];
    entry_t             in_entry [NUM_CH];
    entry_t             head     [NUM_CH];
    logic [PTR_W-1:0]   wr_ptr   [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr   [NUM_CH];
    logic [CNT_W-1:0]   occ      [NUM_CH];
    logic [AGE_W-1:0]   age      [NUM_CH];

    logic [NUM_CH-1:0]       nonempty, urgent, cand, push, pop, in_ready_v;
    logic [NUM_CH*CNT_W-1:0] occ_v;
    logic                    any_urgent, load;
    logic [SRC_W-1:0]        win, rr_ptr, out_src_q;
    logic                    out_valid_q;
    entry_t                  out_q;

    always_comb begin
        in_ready_v = '0;
        occ_v      = '0;
        nonempty   = '0;
        urgent     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_entry[c].id    = bus.in_id[c*ID_WIDTH +: ID_WIDTH];
            in_entry[c].addr  = bus.in_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            in_entry[c].len   = bus.in_len[c*LEN_WIDTH +: LEN_WIDTH];
            in_entry[c].size  = bus.in_size[c*3 +: 3];
            in_entry[c].burst = bus.in_burst[c*2 +: 2];
            in_entry[c].qos   = bus.in_qos[c*4 +: 4];
            in_entry[c].tagid = bus.in_tagid[c*TAG_WIDTH +: TAG_WIDTH];
            head[c]           = mem[c][rd_ptr[c]];
            // No full-bypass: readiness looks only at the registered fill level.
            in_ready_v[c]     = !rst && (occ[c] != CNT_W'(DEPTH));
            occ_v[c*CNT_W +: CNT_W] = occ[c];
            nonempty[c]       = (occ[c] != '0);
            urgent[c]         = nonempty[c] && (age[c] == AGE_W'(AGE_LIMIT));
        end
    end

    always_comb begin : arb
        logic [3:0]     best_qos;
        logic [SRC_W:0] sum;
        logic [SRC_W-1:0] sel;
        logic           found;
        best_qos   = '0;
        sum        = '0;
        sel        = '0;
        found      = 1'b0;
        win        = '0;
        cand       = '0;
        any_urgent = |urgent;
        for (int c = 0; c < NUM_CH; c++) begin
            cand[c] = nonempty[c] && (urgent[c] || !any_urgent);
            if (cand[c] && (head[c].qos > best_qos)) best_qos = head[c].qos;
        end
        // Scan from rr_ptr so equal-priority heads are served in rotation.
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(NUM_CH)) sum = sum - (SRC_W+1)'(NUM_CH);
            sel = sum[SRC_W-1:0];
            if (!found && cand[sel] && (head[sel].qos == best_qos)) begin
                win   = sel;
                found = 1'b1;
            end
        end
    end

    assign load = (|nonempty) && (!out_valid_q || bus.out_ready);

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push[c] = bus.in_valid[c] && in_ready_v[c];
            pop[c]  = load && (win == SRC_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= in_entry[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
                age[c]    <= '0;
            end
            rr_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_src_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])      occ[c] <= occ[c] + 1'b1;
                else if (!push[c] && pop[c]) occ[c] <= occ[c] - 1'b1;
                // Heads only age on cycles where someone else actually won.
                if (pop[c])                     age[c] <= '0;
                else if (nonempty[c] && load)   age[c] <= urgent[c] ? age[c] : age[c] + 1'b1;
                else if (!nonempty[c])          age[c] <= '0;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_q       <= head[win];
                out_src_q   <= win;
                rr_ptr      <= (win == SRC_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_v;
    assign bus.occupancy = occ_v;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_q.id;
    assign bus.out_addr  = out_q.addr;
    assign bus.out_len   = out_q.len;
    assign bus.out_size  = out_q.size;
    assign bus.out_burst = out_q.burst;
    assign bus.out_qos   = out_q.qos;
    assign bus.out_tagid = out_q.tagid;
    assign bus.out_src   = out_src_q;
endmodule
